// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port program RAM between the CPU fetch port
// and a loader port. After reset, RAM access is held off for STARTUP_CYCLES
// cycles so the block RAM contents can settle. On contention the two ports
// take turns. Define IMEM_ARB_LOADER_PRIO_EN to give the loader strict
// priority instead.
module imem_arbiter #(
   parameter int ADDR_W         = 11,
   parameter int DATA_W         = 32,
   parameter int STARTUP_CYCLES = 16000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_gnt_o,
   output logic              fetch_rvalid_o,
   output logic [DATA_W-1:0] fetch_rdata_o,
   input  logic              load_req_i,
   input  logic              load_we_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [DATA_W-1:0] load_wdata_i,
   output logic              load_gnt_o,
   output logic              load_rvalid_o,
   output logic [DATA_W-1:0] load_rdata_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              ready_o
);

   localparam int CNT_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STARTUP_CYCLES);

   typedef enum logic {ST_STARTUP, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fetch_rvalid_q, load_rvalid_q;
   logic             fetch_gnt, load_gnt;

   // Startup countdown; leaves STARTUP on the edge where the counter is zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STARTUP: begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_STARTUP;
         cnt_q   <= CNT_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready_o = (state_q == ST_RUN);

`ifdef IMEM_ARB_LOADER_PRIO_EN
   // Grant select: a lone requester always wins, on contention the loader wins.
   always_comb begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
      if (ready_o) begin
         load_gnt  = load_req_i;
         fetch_gnt = fetch_req_i & ~load_req_i;
      end
   end
`else
   localparam logic PORT_FETCH  = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   logic last_gnt_q, last_gnt_d;

   // Grant select: a lone requester always wins, on contention the port that
   // was not served most recently wins.
   always_comb begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
      if (ready_o) begin
         if (fetch_req_i && load_req_i) begin
            if (last_gnt_q == PORT_LOADER) fetch_gnt = 1'b1;
            else                           load_gnt  = 1'b1;
         end else begin
            fetch_gnt = fetch_req_i;
            load_gnt  = load_req_i;
         end
      end
   end

   // Remember which port was served last; idle cycles leave it unchanged.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (load_gnt)       last_gnt_d = PORT_LOADER;
      else if (fetch_gnt) last_gnt_d = PORT_FETCH;
   end

   // Round-robin pointer; starts at LOADER so the first contention goes to fetch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) last_gnt_q <= PORT_LOADER;
      else         last_gnt_q <= last_gnt_d;
   end
`endif

   assign fetch_gnt_o = fetch_gnt;
   assign load_gnt_o  = load_gnt;
   assign ram_en_o    = fetch_gnt | load_gnt;
   assign ram_we_o    = load_gnt & load_we_i;
   assign ram_addr_o  = load_gnt ? load_addr_i : fetch_addr_i;
   assign ram_wdata_o = load_wdata_i;

   // Read-valid tracks last cycle's read grants (RAM has one cycle of latency).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_rvalid_q <= 1'b0;
         load_rvalid_q  <= 1'b0;
      end else begin
         fetch_rvalid_q <= fetch_gnt;
         load_rvalid_q  <= load_gnt & ~load_we_i;
      end
   end

   assign fetch_rvalid_o = fetch_rvalid_q;
   assign load_rvalid_o  = load_rvalid_q;
   assign fetch_rdata_o  = ram_rdata_i;
   assign load_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic, checked
// every cycle by a monitor against a shadow-memory model of the arbiter.
module tb_imem_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int STC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fetch_req = 1'b0, load_req = 1'b0, load_we = 1'b0;
  logic [AW-1:0] fetch_addr = '0, load_addr = '0;
  logic [DW-1:0] load_wdata = '0;
  logic          fetch_gnt, fetch_rvalid, load_gnt, load_rvalid;
  logic          ram_en, ram_we, ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] fetch_rdata, load_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARTUP_CYCLES(STC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .load_req_i(load_req), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .load_gnt_o(load_gnt), .load_rvalid_o(load_rvalid),
    .load_rdata_o(load_rdata), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .ready_o(ready));

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      0: return 32'h0000_0011;
      1: return 32'h1100_0000;
      2: return 32'h0000_0010;
      3: return 32'h1080_0000;
      default: return (DW'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Registered single-port RAM, one cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // Counters (written only by the monitor).
  int checks = 0, passes = 0;
  // Stimulus -> monitor notifications.
  int   to_seq = 0, imm_seq = 0;
  logic imm_frv = 1'b0, imm_rdy = 1'b0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  // Monitor / scoreboard with reference model.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] fq[$], lq[$];
  initial begin
    int  left = STC + 1, to_seen = 0, imm_seen = 0;
    bit  served_loader = 1'b1, exp_frv = 1'b0, exp_lrv = 1'b0;
    bit  pos_rst, exp_rdy, efg, elg;
    logic [DW-1:0] d;
    for (int i = 0; i < (1<<AW); i++) shadow[i] = init_word(i);
    forever begin
      @(posedge clk); pos_rst = rst_n;
      @(negedge clk);
      if (to_seq != to_seen) begin chk("timeout", 64'(to_seq - to_seen), 0); to_seen = to_seq; end
      if (imm_seq != imm_seen) begin
        imm_seen = imm_seq;
        chk("rst_imm_fetch_rvalid", imm_frv, 0);
        chk("rst_imm_ready", imm_rdy, 0);
      end
      if (!rst_n) begin
        chk("rst_ready", ready, 0);
        chk("rst_gnts", {fetch_gnt, load_gnt}, 0);
        chk("rst_ram_en", {ram_en, ram_we}, 0);
        chk("rst_rvalids", {fetch_rvalid, load_rvalid}, 0);
        left = STC + 1; served_loader = 1'b1; exp_frv = 1'b0; exp_lrv = 1'b0;
        fq.delete(); lq.delete();
      end else begin
        if (pos_rst && left > 0) left--;
        exp_rdy = (left == 0);
        efg = 1'b0; elg = 1'b0;
        if (exp_rdy) begin
          if (fetch_req && load_req) begin
`ifdef IMEM_ARB_LOADER_PRIO_EN
            elg = 1'b1;
`else
            if (served_loader) efg = 1'b1; else elg = 1'b1;
`endif
          end else begin
            efg = fetch_req; elg = load_req;
          end
        end
        chk("ready", ready, exp_rdy);
        chk("fetch_gnt", fetch_gnt, efg);
        chk("load_gnt", load_gnt, elg);
        chk("ram_en", ram_en, efg | elg);
        chk("ram_we", ram_we, elg & load_we);
        if (efg) chk("ram_addr_f", ram_addr, fetch_addr);
        if (elg) chk("ram_addr_l", ram_addr, load_addr);
        if (elg && load_we) chk("ram_wdata", ram_wdata, load_wdata);
        chk("fetch_rvalid", fetch_rvalid, exp_frv);
        chk("load_rvalid", load_rvalid, exp_lrv);
        if (exp_frv) begin d = fq.pop_front(); chk("fetch_rdata", fetch_rdata, d); end
        if (exp_lrv) begin d = lq.pop_front(); chk("load_rdata", load_rdata, d); end
        exp_frv = efg;
        exp_lrv = elg && !load_we;
        if (efg) fq.push_back(shadow[fetch_addr]);
        if (elg) begin
          if (load_we) shadow[load_addr] = load_wdata;
          else         lq.push_back(shadow[load_addr]);
        end
        if (elg) served_loader = 1'b1;
        else if (efg) served_loader = 1'b0;
      end
    end
  end

  // Stimulus.
  bit fg, lg;
  task automatic cyc();
    @(negedge clk); fg = fetch_gnt; lg = load_gnt;
    @(posedge clk); #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] top = '1;
    return ($urandom_range(0, 9) == 0) ? top : AW'($urandom_range(0, 7));
  endfunction

  task automatic issue_fetch(logic [AW-1:0] a);
    bit ok = 1'b0;
    fetch_req = 1'b1; fetch_addr = a;
    for (int k = 0; k < 20 && !ok; k++) begin cyc(); ok = fg; end
    fetch_req = 1'b0;
    if (!ok) to_seq++;
  endtask

  task automatic issue_load(logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
    bit ok = 1'b0;
    load_req = 1'b1; load_we = we; load_addr = a; load_wdata = wd;
    for (int k = 0; k < 20 && !ok; k++) begin cyc(); ok = lg; end
    load_req = 1'b0;
    if (!ok) to_seq++;
  endtask

  task automatic rand_traffic(int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      if (!fetch_req || fg) begin
        fetch_req = 1'($urandom_range(0, 1)); fetch_addr = rand_addr();
      end
      if (!load_req || lg) begin
        load_req = 1'($urandom_range(0, 1)); load_we = 1'($urandom_range(0, 1));
        load_addr = rand_addr(); load_wdata = $urandom;
      end
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Fetch held from reset release, then addresses 0..3 back to back.
    fetch_req = 1'b1; fetch_addr = '0; n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      cyc();
      if (fg) begin n++; fetch_addr = AW'(n); end
    end
    fetch_req = 1'b0;
    if (n < 4) to_seq++;
    cyc();
    // Continuous contention, loader reading.
    fetch_req = 1'b1; load_req = 1'b1; load_we = 1'b0;
    fetch_addr = rand_addr(); load_addr = rand_addr();
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (fg) fetch_addr = rand_addr();
      if (lg) load_addr = rand_addr();
    end
    fetch_req = 1'b0; load_req = 1'b0;
    cyc();
    // Write top address, then fetch it on the next cycle.
    issue_load(1'b1, 11'h7FF, 32'hDEAD_BEEF);
    issue_fetch(11'h7FF);
    issue_load(1'b0, 11'h7FF, '0);
    cyc();
    rand_traffic(400);
    fetch_req = 1'b0; load_req = 1'b0;
    cyc();
    // Reset the cycle after a fetch grant.
    issue_fetch(11'h005);
    rst_n = 1'b0;
    #1 imm_frv = fetch_rvalid; imm_rdy = ready; imm_seq++;
    cyc(); cyc();
    rst_n = 1'b1;
    fetch_req = 1'b1; fetch_addr = rand_addr();
    load_req = 1'b1; load_we = 1'b0; load_addr = rand_addr();
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (fg) fetch_addr = rand_addr();
      if (lg) load_addr = rand_addr();
    end
    rand_traffic(60);
    fetch_req = 1'b0; load_req = 1'b0;
    repeat (3) cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, program RAM word-address width; RAM depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 Parameter STARTUP_CYCLES, default 16000, post-reset cycles during which no RAM access is issued (iCE40 BRAM init settle).
REQ-004 CLK  in  1  single clock, all state on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 fetch_req  in  1  CPU fetch port requests a read this cycle.
REQ-007 fetch_addr  in  ADDR_W  CPU fetch word address.
REQ-008 fetch_gnt  out  1  fetch request accepted this cycle.
REQ-009 fetch_rvalid  out  1  fetch_rdata valid, one cycle after fetch_gnt.
REQ-010 fetch_rdata  out  DATA_W  fetched word.
REQ-011 load_req  in  1  loader port requests an access this cycle.
REQ-012 load_we  in  1  loader access is a write when 1, a read when 0.
REQ-013 load_addr  in  ADDR_W  loader word address.
REQ-014 load_wdata  in  DATA_W  loader write data.
REQ-015 load_gnt  out  1  loader request accepted this cycle.
REQ-016 load_rvalid  out  1  load_rdata valid, one cycle after a granted loader read.
REQ-017 load_rdata  out  DATA_W  loader read data.
REQ-018 ram_en, ram_we  out  1 each  RAM port strobes.
REQ-019 ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W (registered RAM, 1-cycle read latency).
REQ-020 ready  out  1  startup hold-off complete.

Function
REQ-021 Two states SHALL exist: STARTUP (countdown from STARTUP_CYCLES) and RUN; STARTUP->RUN when the counter is 0; STARTUP_CYCLES=0 SHALL enter RUN on the first edge after reset release.
REQ-022 In STARTUP, fetch_gnt, load_gnt, ram_en and ready SHALL be 0 regardless of requests.
REQ-023 In RUN, ready SHALL be 1 and at most one grant SHALL be asserted per cycle; grants are combinational from state, requests and priority pointer.
REQ-024 A granted request SHALL drive ram_en=1, ram_addr, and for loader writes ram_we=1 and ram_wdata, in the same cycle; with no grant ram_en=0, ram_we=0.
REQ-025 Only one requester active: it SHALL be granted every cycle it requests (back-to-back, zero bubbles).
REQ-026 Both requesting (default build): round-robin; 1-bit pointer last_gnt records the last granted port and the other port wins; reset value of last_gnt = LOADER (first contention goes to fetch).
REQ-027 fetch_rvalid / load_rvalid SHALL be registered copies of the previous cycle's read grant; *_rdata SHALL equal ram_rdata while the matching rvalid is high; load_rvalid SHALL stay 0 for writes.
REQ-028 A requester not granted SHALL hold its request and operands; the arbiter SHALL not latch unaccepted requests.
REQ-029 Write then read of the same address on consecutive cycles SHALL return the new data (RAM write-first not assumed: reads follow writes by at least one cycle by construction).
REQ-030 Largest address 2**ADDR_W-1 SHALL pass unmodified; no address arithmetic is performed.

Reset
REQ-031 RST_N low SHALL immediately force: state=STARTUP, counter=STARTUP_CYCLES, last_gnt=LOADER, fetch_rvalid=0, load_rvalid=0, ready=0, all grants and ram strobes 0.
REQ-032 Reset asserted during an outstanding read SHALL drop the pending rvalid; no rvalid SHALL appear after reset release until a new grant.

Configuration
REQ-033 Macro IMEM_ARB_LOADER_PRIO_EN: when defined, loader SHALL have strict priority over fetch on contention and last_gnt is not implemented; when undefined, round-robin per REQ-026.

Verification
REQ-034 STARTUP_CYCLES=4, fetch_req held high from reset release -> fetch_gnt first high on 5th edge, ready rises same cycle, fetch_rvalid one cycle later.
REQ-035 RUN, fetch addr 0..3 back-to-back, RAM preloaded 0x11,0x11000000,0x10,0x10800000 -> fetch_rvalid high 4 consecutive cycles with those words in order.
REQ-036 RUN, both ports request continuously (loader reads) -> grants alternate fetch, loader, fetch, loader; with IMEM_ARB_LOADER_PRIO_EN -> loader granted every cycle, fetch never.
REQ-037 Loader write addr 0x7FF data 0xDEADBEEF, then fetch addr 0x7FF -> fetch_rdata=0xDEADBEEF; load_rvalid stays 0 for the write.
REQ-038 Assert RST_N low the cycle after a fetch grant -> fetch_rvalid 0 immediately and stays 0; ready 0 until STARTUP_CYCLES elapse again.
